// File: rtl/ahfp_mult_arbiter_if.sv
// Requester and multiplier bundle for the shared FP multiplier arbiter.
// master = requester/multiplier side, slave = arbiter side.
interface ahfp_mult_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req;
  logic [32*NREQ-1:0] req_dataa;
  logic [32*NREQ-1:0] req_datab;
  logic [NREQ-1:0]    gnt;
  logic [31:0]        mul_dataa;
  logic [31:0]        mul_datab;
  logic [31:0]        mul_result;
  logic [NREQ-1:0]    rsp_valid;
  logic [31:0]        rsp_result;
  logic               busy;

  modport master (
    output req,
    output req_dataa,
    output req_datab,
    output mul_result,
    input  gnt,
    input  mul_dataa,
    input  mul_datab,
    input  rsp_valid,
    input  rsp_result,
    input  busy
  );

  modport slave (
    input  req,
    input  req_dataa,
    input  req_datab,
    input  mul_result,
    output gnt,
    output mul_dataa,
    output mul_datab,
    output rsp_valid,
    output rsp_result,
    output busy
  );
endinterface

// File: rtl/ahfp_mult_arbiter.sv
// Round-robin arbiter sharing one combinational FP multiplier.
// Two-stage pipeline: operand capture, then registered product return.
module ahfp_mult_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  ahfp_mult_arbiter_if.slave   bus
);

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  win_id;
  logic            win_vld;
  logic [NREQ-1:0] gnt_w;
  logic            grant;
  logic [31:0]     win_a;
  logic [31:0]     win_b;
  logic [IDW-1:0]  ptr_nxt;

  logic            s1_valid;
  logic [IDW-1:0]  s1_id;
  logic [NREQ-1:0] s1_oh;
  logic [31:0]     mul_a_q;
  logic [31:0]     mul_b_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [31:0]     rsp_result_q;

  // Search from ptr upward with wrap; first requester found wins.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_id  = '0;
    for (int j = 0; j < NREQ; j++) begin
      idx = int'(ptr) + j;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_vld && bus.req[idx]) begin
        win_vld = 1'b1;
        win_id  = IDW'(idx);
      end
    end
  end

  // No grant while stalled or held in reset.
  always_comb begin
    gnt_w = '0;
    if (clk_en && reset && win_vld)
      gnt_w[win_id] = 1'b1;
  end

  assign grant = |gnt_w;

  always_comb begin
    win_a = bus.req_dataa[32*int'(win_id) +: 32];
    win_b = bus.req_datab[32*int'(win_id) +: 32];
  end

  always_comb begin
    if (win_id == IDW'(NREQ-1))
      ptr_nxt = '0;
    else
      ptr_nxt = win_id + 1'b1;
  end

  always_comb begin
    s1_oh        = '0;
    s1_oh[s1_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr          <= '0;
      s1_valid     <= 1'b0;
      s1_id        <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
    end else if (clk_en) begin
      s1_valid <= grant;
      s1_id    <= win_id;
      if (grant) begin
        ptr     <= ptr_nxt;
        mul_a_q <= win_a;
        mul_b_q <= win_b;
      end
      rsp_valid_q <= s1_valid ? s1_oh : '0;
      if (s1_valid)
        rsp_result_q <= bus.mul_result;
    end
  end

  assign bus.gnt        = gnt_w;
  assign bus.mul_dataa  = mul_a_q;
  assign bus.mul_datab  = mul_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.busy       = s1_valid | (|rsp_valid_q);

endmodule

// File: tb/tb_ahfp_mult_arbiter.sv
// Directed bench for ahfp_mult_arbiter with a stub multiplier.
// Grant order is hand-listed; responses scoreboarded by cycle.
module tb_ahfp_mult_arbiter;

  logic clk;
  logic rst_n;
  logic clk_en;

  ahfp_mult_arbiter_if #(.NREQ(4)) bus ();

  ahfp_mult_arbiter #(
    .NREQ(4),
    .IDW (2)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .clk_en(clk_en),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fmul(input logic [31:0] a,
                                       input logic [31:0] b);
    if (a == 32'h4000_0000 && b == 32'h4040_0000)
      return 32'h40C0_0000;
    return a ^ {b[15:0], b[31:16]};
  endfunction

  assign bus.mul_result = fmul(bus.mul_dataa, bus.mul_datab);

  int n_chk = 0;
  int n_err = 0;
  int ecyc  = 0;

  logic [31:0] op_a [4];
  logic [31:0] op_b [4];
  logic [3:0]  exp_v [256];
  logic [31:0] exp_r [256];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load_ops();
    for (int i = 0; i < 4; i++) begin
      bus.req_dataa[32*i +: 32] = op_a[i];
      bus.req_datab[32*i +: 32] = op_b[i];
    end
  endtask

  task automatic clr_sb();
    for (int i = 0; i < 256; i++) begin
      exp_v[i] = '0;
      exp_r[i] = '0;
    end
  endtask

  task automatic run_cycle(input string tag, input logic [3:0] eg);
    int id;
    logic bsy;
    id = 0;
    #1;
    chk({tag, " gnt"}, 32'(bus.gnt), 32'(eg));
    chk({tag, " rsp_v"}, 32'(bus.rsp_valid), 32'(exp_v[ecyc]));
    if (exp_v[ecyc] != 0)
      chk({tag, " rsp_r"}, bus.rsp_result, exp_r[ecyc]);
    bsy = (exp_v[ecyc] != 0) || (exp_v[ecyc+1] != 0);
    chk({tag, " busy"}, 32'(bus.busy), 32'(bsy));
    if (eg != 0) begin
      for (int i = 0; i < 4; i++)
        if (eg[i]) id = i;
      exp_v[ecyc+2] = eg;
      exp_r[ecyc+2] = fmul(op_a[id], op_b[id]);
    end
    @(posedge clk);
    if (clk_en) ecyc++;
    #1;
  endtask

  initial begin
    clr_sb();
    for (int i = 0; i < 4; i++) begin
      op_a[i] = 32'h3F80_0000 + 32'(i) * 32'h0010_0000;
      op_b[i] = 32'h4000_0000 + 32'(i) * 32'h0008_0000;
    end
    load_ops();
    rst_n   = 1'b0;
    clk_en  = 1'b1;
    bus.req = 4'b1111;

    repeat (3) @(posedge clk);
    #1;
    chk("rst gnt", 32'(bus.gnt), 32'h0);
    chk("rst rsp_v", 32'(bus.rsp_valid), 32'h0);
    chk("rst busy", 32'(bus.busy), 32'h0);
    chk("rst mul_a", bus.mul_dataa, 32'h0);
    chk("rst rsp_r", bus.rsp_result, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rel gnt", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0000;
    run_cycle("idle", 4'b0000);

    // single op from requester 2, ptr at 0
    op_a[2] = 32'h4000_0000;
    op_b[2] = 32'h4040_0000;
    load_ops();
    bus.req = 4'b0100;
    run_cycle("one k", 4'b0100);
    bus.req = 4'b0000;
    chk("one mul_a", bus.mul_dataa, 32'h4000_0000);
    chk("one mul_b", bus.mul_datab, 32'h4040_0000);
    run_cycle("one k1", 4'b0000);
    chk("one prod", bus.rsp_result, 32'h40C0_0000);
    run_cycle("one k2", 4'b0000);
    run_cycle("one k3", 4'b0000);
    chk("one hold", bus.rsp_result, 32'h40C0_0000);

    // round robin from ptr 3
    op_a[2] = 32'h3F80_0000 + 32'h0020_0000;
    op_b[2] = 32'h4000_0000 + 32'h0010_0000;
    load_ops();
    bus.req = 4'b1111;
    run_cycle("rr0", 4'b1000);
    run_cycle("rr1", 4'b0001);
    run_cycle("rr2", 4'b0010);
    run_cycle("rr3", 4'b0100);
    run_cycle("rr4", 4'b1000);
    run_cycle("rr5", 4'b0001);
    run_cycle("rr6", 4'b0010);
    run_cycle("rr7", 4'b0100);
    run_cycle("rr8", 4'b1000);
    run_cycle("rr9", 4'b0001);
    bus.req = 4'b0000;
    run_cycle("rr d0", 4'b0000);
    run_cycle("rr d1", 4'b0000);

    // skip idle requesters 1 and 2, ptr at 1
    bus.req = 4'b1001;
    run_cycle("fr0", 4'b1000);
    run_cycle("fr1", 4'b0001);
    run_cycle("fr2", 4'b1000);
    run_cycle("fr3", 4'b0001);
    bus.req = 4'b0000;
    run_cycle("fr d0", 4'b0000);
    run_cycle("fr d1", 4'b0000);

    // stall with two ops in flight, ptr at 1
    bus.req = 4'b0011;
    run_cycle("st g0", 4'b0010);
    run_cycle("st g1", 4'b0001);
    clk_en = 1'b0;
    run_cycle("st s0", 4'b0000);
    run_cycle("st s1", 4'b0000);
    run_cycle("st s2", 4'b0000);
    chk("st mul_a", bus.mul_dataa, op_a[0]);
    clk_en  = 1'b1;
    bus.req = 4'b0000;
    run_cycle("st r0", 4'b0000);
    run_cycle("st r1", 4'b0000);
    run_cycle("st r2", 4'b0000);

    // reset one cycle after a grant, ptr at 1
    bus.req = 4'b0100;
    run_cycle("mr g", 4'b0100);
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    #1;
    chk("mr rsp_v", 32'(bus.rsp_valid), 32'h0);
    chk("mr busy", 32'(bus.busy), 32'h0);
    chk("mr mul_a", bus.mul_dataa, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("mr hold v", 32'(bus.rsp_valid), 32'h0);
    end
    rst_n = 1'b1;
    clr_sb();
    bus.req = 4'b1111;
    run_cycle("mr ptr", 4'b0001);
    bus.req = 4'b0000;
    run_cycle("mr p0", 4'b0000);
    run_cycle("mr p1", 4'b0000);
    run_cycle("mr p2", 4'b0000);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ahfp_mult_arbiter.md
Name: ahfp_mult_arbiter

Overview:
Round-robin arbiter and sequencer that shares one combinational floating-point multiplier (ahfp_mult_combi) between NREQ requesters. It accepts at most one operand pair per cycle and registers the operands into the multiplier. It registers the product and returns it to the winning requester, tagged one-hot, a fixed 2 cycles after grant. It sits between the custom-instruction front ends and the single shared multiplier instance.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of the internal requester index; must equal ceil(log2(NREQ))

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; clears all state
clk_en  in  1  global enable; low freezes every register and forces gnt to 0
req  in  NREQ  per-requester request; held with operands until granted
req_dataa  in  32*NREQ  packed operand A; requester i uses bits [32i+31:32i]
req_datab  in  32*NREQ  packed operand B, same packing
gnt  out  NREQ  one-hot grant, combinational; operands are captured on the edge where gnt[i]=1 and clk_en=1
mul_dataa  out  32  registered operand A to the shared multiplier
mul_datab  out  32  registered operand B to the shared multiplier
mul_result  in  32  combinational product from the shared multiplier
rsp_valid  out  NREQ  registered one-hot; result is for requester i
rsp_result  out  32  registered product
busy  out  1  high while any operation is in stage 1 or stage 2

Behaviour:
- Reset (reset=0, asynchronous) clears the following: ptr=0, s1_valid=0, s1_id=0, mul_dataa=0, mul_datab=0, rsp_valid=0, rsp_result=0. gnt is 0 because req is ignored during reset. busy=0. In-flight operations are discarded and produce no response. After reset deasserts, the first grant can occur on the next rising edge.
- Arbitration, combinational:
  - Search req starting at index ptr, ascending, wrapping modulo NREQ. The first set bit wins.
  - gnt is one-hot or zero. gnt=0 when clk_en=0 or req=0.
  - A requester already holding a grant has no special priority.
- Pointer update, on an edge with clk_en=1:
  - If a grant was given to requester i: ptr <= (i+1) mod NREQ.
  - Otherwise ptr is unchanged.
- Stage 1, on an edge with clk_en=1:
  - s1_valid <= |gnt.
  - s1_id <= winner index.
  - mul_dataa/mul_datab <= the winner's operands.
  - With no grant, the operand registers hold their previous values and s1_valid <= 0.
- Stage 2, on an edge with clk_en=1:
  - rsp_valid <= s1_valid ? (1 << s1_id) : 0.
  - rsp_result <= s1_valid ? mul_result : rsp_result (held when no result).
- Latency and throughput:
  - A grant in cycle k yields rsp_valid during cycle k+2, when clk_en is continuously high.
  - Throughput is one operation per cycle, with no bubbles under back-to-back requests.
  - Responses return in grant order.
- rsp_valid is a pulse of one enabled cycle. Consumers sample it only when clk_en=1.
- clk_en=0:
  - All registers hold, including rsp_valid and rsp_result, which remain at their values.
  - gnt=0, so no operand is captured and ptr does not move.
  - Resuming clk_en continues the pipeline exactly where it stopped.
- busy = s1_valid | (|rsp_valid).
- Requester protocol: req and operands must stay stable until gnt[i] is seen. Deasserting req before grant withdraws the request with no side effects.
- Simultaneous grant and response to the same requester is legal; the requester may re-request while its previous result is in flight.
- The block performs no arithmetic. Product correctness is owned by the multiplier.

Test Plan:
- Reset value check: hold reset=0 and drive req=4'b1111 -> gnt=0, rsp_valid=0, busy=0, mul_dataa=0. Release reset at edge 3 -> gnt=4'b0001 is visible after edge 3 releases.
- Single op: requester 2 drives 0x40000000 × 0x40400000 (2.0×3.0), granted in cycle k -> rsp_valid=4'b0100 and rsp_result=0x40C00000 (6.0) in cycle k+2. busy is high in cycles k+1 and k+2.
- Round robin: req=4'b1111 held for 8 cycles with distinct operands -> gnt sequence 0001,0010,0100,1000,0001,... Responses return in the same order with matching products, one per cycle.
- Fairness and skip: req=4'b1001 continuously with ptr=1 -> gnt order 3,0,3,0. Requesters 1 and 2 are never granted.
- clk_en stall: clk_en=0 for 3 cycles while 2 ops are in flight -> gnt=0 and rsp_valid/rsp_result frozen. On resume, the remaining response appears one enabled cycle later with the correct id.
- Reset mid-operation: assert reset one cycle after a grant -> rsp_valid stays 0 through and after reset, ptr=0, and no stale response appears.
